pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Pipeline hazard and redirect controller for the 5-stage core.
- Collects stall requests from ID, EX and MEM, and the branch outcome from EX.
- Drives per-stage hold and flush vectors, and the mispredict flag consumed by pc.
- Sequences multi-cycle flushes, defers a redirect that arrives under a memory stall, and keeps stall/flush event counters.

Parameters:
- FLUSH_CYC, 2, cycles IF/ID and ID/EX stay flushed after a redirect (1..7).
- BUSY_TIMEOUT, 64, consecutive ex_busy_i cycles before timeout_o pulses (2..255).
- CNT_W, 32, width of performance counters.

Ports:
- clk  in  1  core clock
- rstn  in  1  asynchronous active-low reset
- id_load_use_i  in  1  load-use hazard detected in ID
- ex_busy_i  in  1  multi-cycle EX unit (div) busy
- mem_wait_i  in  1  data bus not ready
- ex_br_valid_i  in  1  EX holds a branch/jump with resolved outcome this cycle
- ex_jump_en_i  in  1  resolved outcome: taken
- ex_prd_taken_i  in  1  prediction carried with that instruction
- hold_en_o  out  5  hold per stage: [0]=pc [1]=if/id [2]=id/ex [3]=ex/mem [4]=mem/wb
- flush_o  out  5  bubble insert per stage register, same indexing
- prd_fail_o  out  1  mispredict redirect to pc; qualified by hold_en_o[0]
- timeout_o  out  1  one-cycle pulse on EX busy watchdog expiry
- stall_cnt_o  out  CNT_W  total cycles with any hold_en_o bit set
- flush_cnt_o  out  CNT_W  number of redirects issued

Behaviour:
- Reset (async, rstn=0): state=RUN, all outputs 0, counters 0, pending redirect 0, flush counter 0, watchdog 0.
- mispredict = ex_br_valid_i & (ex_jump_en_i != ex_prd_taken_i); combinational from inputs.
- Priority per cycle: mem_wait_i > ex_busy_i > mispredict/pending > id_load_use_i.
- mem_wait_i=1:
  - hold_en_o=5'b11111, flush_o=0.
  - A mispredict seen this cycle sets pending, which is held until issued.
- ex_busy_i=1 (no mem_wait):
  - hold_en_o=5'b00111, flush_o[3]=1 (bubble into EX/MEM).
  - Mispredict cannot coincide; ex_br_valid_i is ignored while busy.
- Redirect (mispredict or pending, no higher stall):
  - Same cycle: hold_en_o[0]=1, prd_fail_o=1, flush_o=5'b00110.
  - Enter FLUSH with counter=FLUSH_CYC-1; pending cleared; flush_cnt_o+1.
  - If FLUSH_CYC=1, return to RUN directly.
- FLUSH state:
  - flush_o=5'b00110, hold_en_o[0]=0, prd_fail_o=0; counter decrements each cycle.
  - At 0 → RUN.
  - mem_wait_i during FLUSH: hold all stages, counter frozen.
  - A new mispredict in FLUSH is ignored (EX holds a bubble by construction).
- Load-use (RUN, nothing higher):
  - hold_en_o=5'b00011, flush_o=5'b00100 for exactly that cycle.
  - Comes back RUN; no state change.
- prd_fail_o is asserted only together with hold_en_o[0]=1 and never in any other cycle.
- Watchdog:
  - Counts consecutive ex_busy_i cycles, saturating at BUSY_TIMEOUT.
  - timeout_o=1 for the single cycle the count reaches BUSY_TIMEOUT.
  - Cleared when ex_busy_i=0.
- Counters:
  - stall_cnt_o increments in every cycle where |hold_en_o=1; wraps modulo 2^CNT_W.
  - flush_cnt_o wraps modulo 2^CNT_W.
- Outputs hold_en_o/flush_o/prd_fail_o are combinational from state and inputs (same-cycle response). Counters and timeout_o are registered.
- Reset mid-FLUSH or mid-pending: everything returns to reset values immediately; the pending redirect is discarded.

Decomposition:
- Shared defines file gets:
  - stage index constants PC_IDX..WB_IDX
  - HoldEnable/JumpEnable values
  - FSM encodings RUN=2'd0, FLUSH=2'd1
- One sub-module is natural: pipe_perf_cnt, holding the two wrap-around counters and the watchdog.

Test Plan:
- Reset then idle 10 cycles → hold_en_o=0, flush_o=0, prd_fail_o=0, counters 0.
- ex_br_valid_i=1, ex_jump_en_i=1, ex_prd_taken_i=0, 1 cycle, FLUSH_CYC=2 → cycle0: hold_en_o=00001, prd_fail_o=1, flush_o=00110; cycle1: flush_o=00110, prd_fail_o=0; cycle2: flush_o=0; flush_cnt_o=1.
- Mispredict while mem_wait_i=1 for 3 cycles → hold_en_o=11111 for those 3 cycles, no prd_fail_o; on the first free cycle prd_fail_o=1; stall_cnt_o=4.
- id_load_use_i=1 one cycle → hold_en_o=00011, flush_o=00100 for 1 cycle only.
- ex_busy_i=1 for 70 cycles, BUSY_TIMEOUT=64 → timeout_o single pulse at cycle 64, hold_en_o=00111 throughout.
- Assert rstn=0 during FLUSH counter=1 → all outputs 0 asynchronously; after release, state=RUN and no flush.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/redirect controller.
//   - stage index constants for the hold_en/flush vectors
//   - hold/jump encodings
//   - per-situation hold and flush masks built from the stage indices
//   - FSM state encoding
package pipe_ctrl_pkg;

  localparam int N_STAGE = 5;

  // Stage indices into hold_en_o / flush_o.
  localparam int PC_IDX  = 0;
  localparam int IF_IDX  = 1;
  localparam int ID_IDX  = 2;
  localparam int EX_IDX  = 3;
  localparam int WB_IDX  = 4;

  localparam logic HOLD_ENABLE  = 1'b1;
  localparam logic HOLD_DISABLE = 1'b0;
  localparam logic JUMP_ENABLE  = 1'b1;
  localparam logic JUMP_DISABLE = 1'b0;

  // Hold masks.
  localparam logic [N_STAGE-1:0] HOLD_NONE = '0;
  localparam logic [N_STAGE-1:0] HOLD_PC   = 5'b1 << PC_IDX;
  localparam logic [N_STAGE-1:0] HOLD_LU   = (5'b1 << PC_IDX) | (5'b1 << IF_IDX);
  localparam logic [N_STAGE-1:0] HOLD_BUSY = (5'b1 << PC_IDX) | (5'b1 << IF_IDX) |
                                             (5'b1 << ID_IDX);
  localparam logic [N_STAGE-1:0] HOLD_ALL  = (5'b1 << PC_IDX) | (5'b1 << IF_IDX) |
                                             (5'b1 << ID_IDX) | (5'b1 << EX_IDX) |
                                             (5'b1 << WB_IDX);

  // Flush (bubble insert) masks.
  localparam logic [N_STAGE-1:0] FLUSH_NONE  = '0;
  localparam logic [N_STAGE-1:0] FLUSH_LU    = 5'b1 << ID_IDX;
  localparam logic [N_STAGE-1:0] FLUSH_EX    = 5'b1 << EX_IDX;
  localparam logic [N_STAGE-1:0] FLUSH_REDIR = (5'b1 << IF_IDX) | (5'b1 << ID_IDX);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1
  } pipe_state_e;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Event counters and EX-busy watchdog for pipe_ctrl.
//   clk, rstn     : clock, async active-low reset
//   stall_i       : some hold bit is set this cycle
//   redirect_i    : a redirect is issued this cycle
//   ex_busy_i     : multi-cycle EX unit busy
//   timeout_o     : one-cycle pulse when the busy run reaches BUSY_TIMEOUT
//   stall_cnt_o   : wrap-around count of stalled cycles
//   flush_cnt_o   : wrap-around count of redirects
module pipe_perf_cnt #(
  parameter int BUSY_TIMEOUT = 64,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic             ex_busy_i,
  output logic             timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [7:0] BT8 = 8'(BUSY_TIMEOUT);

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [7:0]       busy_cnt_q, busy_cnt_d;
  logic             timeout_q, timeout_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    busy_cnt_d  = 8'd0;
    timeout_d   = 1'b0;
    if (stall_i)    stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (redirect_i) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    if (ex_busy_i) begin
      // Saturate so a very long busy run pulses timeout only once.
      busy_cnt_d = (busy_cnt_q == BT8) ? busy_cnt_q : busy_cnt_q + 8'd1;
      timeout_d  = (busy_cnt_q == BT8 - 8'd1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      busy_cnt_q  <= 8'd0;
      timeout_q   <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      busy_cnt_q  <= busy_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign timeout_o   = timeout_q;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard and redirect controller for the 5-stage core.
// Inputs: stall requests (id_load_use_i, ex_busy_i, mem_wait_i) and the EX
// branch outcome (ex_br_valid_i, ex_jump_en_i, ex_prd_taken_i).
// Outputs: per-stage hold_en_o / flush_o ([0]=pc .. [4]=mem/wb), prd_fail_o
// (redirect to pc, always with hold_en_o[0]), timeout_o (EX busy watchdog),
// stall_cnt_o / flush_cnt_o (event counters), dbg_state_o (FSM state).
// Stage controls are combinational from state and inputs; there is no
// handshake, every cycle is evaluated on its own.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYC    = 2,
  parameter int BUSY_TIMEOUT = 64,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             id_load_use_i,
  input  logic             ex_busy_i,
  input  logic             mem_wait_i,
  input  logic             ex_br_valid_i,
  input  logic             ex_jump_en_i,
  input  logic             ex_prd_taken_i,
  output logic [4:0]       hold_en_o,
  output logic [4:0]       flush_o,
  output logic             prd_fail_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [1:0]       dbg_state_o
);

  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYC - 1);

  pipe_state_e state_q, state_d;
  logic [2:0]  fcnt_q, fcnt_d;
  logic        pend_q, pend_d;

  logic        mispredict;
  logic [4:0]  hold, flush;
  logic        prd_fail, redirect;

  always_comb begin
    mispredict = ex_br_valid_i & (ex_jump_en_i != ex_prd_taken_i);
    hold       = HOLD_NONE;
    flush      = FLUSH_NONE;
    prd_fail   = 1'b0;
    redirect   = 1'b0;
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    pend_d     = pend_q;
    if (mem_wait_i) begin
      hold = HOLD_ALL;
      // Park the redirect until the bus frees; in FLUSH EX holds a bubble.
      if (state_q == RUN && mispredict) pend_d = 1'b1;
    end else if (ex_busy_i) begin
      // Branch info is ignored while busy; a parked redirect keeps waiting.
      hold  = HOLD_BUSY;
      flush = FLUSH_EX;
    end else if (state_q == FLUSH) begin
      flush = FLUSH_REDIR;
      if (fcnt_q <= 3'd1) begin
        state_d = RUN;
        fcnt_d  = 3'd0;
      end else begin
        fcnt_d = fcnt_q - 3'd1;
      end
    end else if (mispredict || pend_q) begin
      hold[PC_IDX] = HOLD_ENABLE;
      prd_fail     = 1'b1;
      flush        = FLUSH_REDIR;
      redirect     = 1'b1;
      pend_d       = 1'b0;
      if (FLUSH_INIT != 3'd0) begin
        state_d = FLUSH;
        fcnt_d  = FLUSH_INIT;
      end
    end else if (id_load_use_i) begin
      hold  = HOLD_LU;
      flush = FLUSH_LU;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= RUN;
      fcnt_q  <= 3'd0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      pend_q  <= pend_d;
    end
  end

  // Reset forces the stage controls low immediately, not just at the next edge.
  assign hold_en_o   = rstn ? hold     : 5'b0;
  assign flush_o     = rstn ? flush    : 5'b0;
  assign prd_fail_o  = rstn ? prd_fail : 1'b0;
  assign dbg_state_o = state_q;

  pipe_perf_cnt #(
    .BUSY_TIMEOUT (BUSY_TIMEOUT),
    .CNT_W        (CNT_W)
  ) u_perf (
    .clk         (clk),
    .rstn        (rstn),
    .stall_i     (|hold),
    .redirect_i  (redirect),
    .ex_busy_i   (ex_busy_i),
    .timeout_o   (timeout_o),
    .stall_cnt_o (stall_cnt_o),
    .flush_cnt_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus randomized traffic, expected
// responses from a behavioural model pushed to a queue, compared by a monitor.
module tb_pipe_ctrl;

  localparam int FLUSH_CYC    = 2;
  localparam int BUSY_TIMEOUT = 64;
  localparam int CNT_W        = 32;
  localparam int W            = 2 + 5 + 5 + 1 + 1 + CNT_W + CNT_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic             id_load_use_i = 0, ex_busy_i = 0, mem_wait_i = 0;
  logic             ex_br_valid_i = 0, ex_jump_en_i = 0, ex_prd_taken_i = 0;
  logic [4:0]       hold_en_o, flush_o;
  logic             prd_fail_o, timeout_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;
  logic [1:0]       dbg_state_o;

  pipe_ctrl #(
    .FLUSH_CYC    (FLUSH_CYC),
    .BUSY_TIMEOUT (BUSY_TIMEOUT),
    .CNT_W        (CNT_W)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .id_load_use_i  (id_load_use_i),
    .ex_busy_i      (ex_busy_i),
    .mem_wait_i     (mem_wait_i),
    .ex_br_valid_i  (ex_br_valid_i),
    .ex_jump_en_i   (ex_jump_en_i),
    .ex_prd_taken_i (ex_prd_taken_i),
    .hold_en_o      (hold_en_o),
    .flush_o        (flush_o),
    .prd_fail_o     (prd_fail_o),
    .timeout_o      (timeout_o),
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o),
    .dbg_state_o    (dbg_state_o)
  );

  // ---------------- reference model ----------------
  int               m_flush_left = 0;  // flushed cycles still owed after a redirect
  bit               m_pending    = 0;  // redirect parked behind a memory stall
  int               m_busy_run   = 0;  // consecutive busy cycles seen (saturating)
  bit               m_timeout    = 0;
  logic [CNT_W-1:0] m_stalls     = '0;
  logic [CNT_W-1:0] m_flushes    = '0;

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic model_reset();
    m_flush_left = 0;
    m_pending    = 0;
    m_busy_run   = 0;
    m_timeout    = 0;
    m_stalls     = '0;
    m_flushes    = '0;
  endtask

  // ---------------- driver ----------------
  task automatic drive_cycle(input logic r, input logic lu, input logic busy,
                             input logic mw, input logic bv, input logic je,
                             input logic pt);
    logic [4:0] e_hold, e_flush;
    logic       e_prd, mis;
    logic [1:0] e_state;
    @(posedge clk);
    #1;
    rstn           = r;
    id_load_use_i  = lu;
    ex_busy_i      = busy;
    mem_wait_i     = mw;
    ex_br_valid_i  = bv;
    ex_jump_en_i   = je;
    ex_prd_taken_i = pt;
    if (!r) begin
      model_reset();
      exp_q.push_back('0);
    end else begin
      mis     = bv && (je != pt);
      e_hold  = 5'b00000;
      e_flush = 5'b00000;
      e_prd   = 1'b0;
      e_state = (m_flush_left > 0) ? 2'd1 : 2'd0;
      if (mw) begin
        e_hold = 5'b11111;
        if (m_flush_left == 0 && mis) m_pending = 1;
      end else if (busy) begin
        e_hold  = 5'b00111;
        e_flush = 5'b01000;
      end else if (m_flush_left > 0) begin
        e_flush = 5'b00110;
        m_flush_left--;
      end else if (mis || m_pending) begin
        e_hold       = 5'b00001;
        e_prd        = 1'b1;
        e_flush      = 5'b00110;
        m_pending    = 0;
        m_flush_left = FLUSH_CYC - 1;
      end else if (lu) begin
        e_hold  = 5'b00011;
        e_flush = 5'b00100;
      end
      // Registered values visible now reflect everything before this cycle.
      exp_q.push_back({e_state, e_hold, e_flush, e_prd, m_timeout, m_stalls, m_flushes});
      if (e_prd) m_flushes = m_flushes + 1'b1;
      if (e_hold != 0) m_stalls = m_stalls + 1'b1;
      if (busy) begin
        m_timeout  = (m_busy_run + 1 == BUSY_TIMEOUT);
        m_busy_run = (m_busy_run + 1 > BUSY_TIMEOUT) ? BUSY_TIMEOUT : m_busy_run + 1;
      end else begin
        m_timeout  = 0;
        m_busy_run = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1, 0, 0, 0, 0, 0, 0);
  endtask

  // ---------------- scoreboard / monitor ----------------
  task automatic check(input string name, input logic [CNT_W-1:0] act,
                       input logic [CNT_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("state",     CNT_W'(dbg_state_o), CNT_W'(e[W-1 -: 2]));
      check("hold_en",   CNT_W'(hold_en_o),   CNT_W'(e[W-3 -: 5]));
      check("flush",     CNT_W'(flush_o),     CNT_W'(e[W-8 -: 5]));
      check("prd_fail",  CNT_W'(prd_fail_o),  CNT_W'(e[2*CNT_W+1]));
      check("timeout",   CNT_W'(timeout_o),   CNT_W'(e[2*CNT_W]));
      check("stall_cnt", stall_cnt_o,         e[2*CNT_W-1 -: CNT_W]);
      check("flush_cnt", flush_cnt_o,         e[CNT_W-1:0]);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic busy_r;
    busy_r = 0;
    // reset, then idle
    drive_cycle(0, 0, 0, 0, 0, 0, 0);
    drive_cycle(0, 0, 0, 0, 0, 0, 0);
    idle(10);
    // single mispredict (taken, predicted not taken)
    drive_cycle(1, 0, 0, 0, 1, 1, 0);
    idle(3);
    // mispredict under a 3-cycle memory stall
    drive_cycle(1, 0, 0, 1, 1, 0, 1);
    drive_cycle(1, 0, 0, 1, 0, 0, 0);
    drive_cycle(1, 0, 0, 1, 0, 0, 0);
    idle(4);
    // single load-use cycle
    drive_cycle(1, 1, 0, 0, 0, 0, 0);
    idle(2);
    // long busy run crossing the watchdog threshold, branch info ignored
    for (int i = 0; i < 70; i++) drive_cycle(1, 0, 1, 0, (i % 5) == 0, 1, 0);
    idle(3);
    // memory stall in the middle of FLUSH freezes it
    drive_cycle(1, 0, 0, 0, 1, 0, 1);
    drive_cycle(1, 0, 0, 1, 1, 1, 0);
    idle(3);
    // reset while FLUSH counter is 1 with a parked redirect in flight
    drive_cycle(1, 0, 0, 1, 1, 1, 0);
    drive_cycle(1, 0, 0, 0, 0, 0, 0);
    drive_cycle(0, 1, 1, 0, 1, 1, 0);
    drive_cycle(0, 0, 0, 0, 0, 0, 0);
    idle(3);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      busy_r = busy_r ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 19) == 0);
      drive_cycle($urandom_range(0, 399) != 0,
                  $urandom_range(0, 4) == 0,
                  busy_r,
                  $urandom_range(0, 6) == 0,
                  $urandom_range(0, 2) == 0,
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
    end
    idle(2);
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
